fft_frame_sequencer: RTL and testbench

Frame-level controller for the in-place FFT core in the ADC-to-spectrum path. Takes a free-running ADC sample stream, converts offset-binary samples to signed complex input, loads exactly POINTS samples per frame into the FFT core when its buffer is ready, triggers the output read once the transform completes, and re-emits the result as indexed spectral bins. Tracks dropped samples and core stalls for the host.

---
 rtl/fft_frame_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: frame-level controller for an in-place FFT core.
// Loads POINTS offset-binary ADC samples per frame as signed complex input,
// triggers the result read once the transform is done, and re-emits the
// result as indexed spectral bins. Counts dropped samples and flags core stalls.
module fft_frame_sequencer #(
  parameter int unsigned POINTS   = 256,
  parameter int unsigned WIDTH    = 18,
  parameter int unsigned ADC_BITS = 12,
  parameter int unsigned TIMEOUT  = 4095
) (
  input  logic                       CLK,
  input  logic                       NGRST,
  input  logic                       ENABLE,
  input  logic [ADC_BITS-1:0]        ADC_DATA,
  input  logic                       ADC_VALID,
  input  logic                       FFT_BUF_READY,
  output logic [WIDTH-1:0]           FFT_DATAI_RE,
  output logic [WIDTH-1:0]           FFT_DATAI_IM,
  output logic                       FFT_DATAI_VALID,
  input  logic                       FFT_OUTP_READY,
  output logic                       FFT_READ_OUTP,
  input  logic [WIDTH-1:0]           FFT_DATAO_RE,
  input  logic [WIDTH-1:0]           FFT_DATAO_IM,
  input  logic                       FFT_DATAO_VALID,
  output logic [WIDTH-1:0]           BIN_RE,
  output logic [WIDTH-1:0]           BIN_IM,
  output logic [$clog2(POINTS)-1:0]  BIN_IDX,
  output logic                       BIN_VALID,
  output logic                       FRAME_DONE,
  output logic                       BUSY,
  output logic [7:0]                 DROP_CNT,
  output logic                       ERR_TIMEOUT
);

  localparam int unsigned IDX_W  = $clog2(POINTS);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(POINTS - 1);
  localparam logic [IDLE_W-1:0]   IDLE_LIMIT = IDLE_W'(TIMEOUT);
  localparam logic [ADC_BITS-1:0] ADC_MSB    = ADC_BITS'(1) << (ADC_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_OUT,
    S_READ,
    S_UNLOAD
  } state_e;

  state_e               state_q,       state_d;
  logic [IDX_W-1:0]     sample_cnt_q,  sample_cnt_d;
  logic [IDX_W-1:0]     bin_cnt_q,     bin_cnt_d;
  logic [IDLE_W-1:0]    idle_cnt_q,    idle_cnt_d;
  logic [7:0]           drop_cnt_q,    drop_cnt_d;
  logic                 err_q,         err_d;
  logic [WIDTH-1:0]     datai_re_q,    datai_re_d;
  logic                 datai_valid_q, datai_valid_d;
  logic                 read_outp_q,   read_outp_d;
  logic [WIDTH-1:0]     bin_re_q,      bin_re_d;
  logic [WIDTH-1:0]     bin_im_q,      bin_im_d;
  logic [IDX_W-1:0]     bin_idx_q,     bin_idx_d;
  logic                 bin_valid_q,   bin_valid_d;
  logic                 frame_done_q,  frame_done_d;

  // Offset-binary to two's complement is just an MSB flip; the cast then
  // sign-extends to the core width.
  logic signed [ADC_BITS-1:0] adc_signed;
  logic [IDLE_W-1:0]          idle_inc;

  assign adc_signed = ADC_DATA ^ ADC_MSB;
  assign idle_inc   = idle_cnt_q + 1'b1;

  // Next-state and next-output computation for the frame FSM.
  always_comb begin
    state_d       = state_q;
    sample_cnt_d  = sample_cnt_q;
    bin_cnt_d     = bin_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    err_d         = err_q;
    datai_re_d    = datai_re_q;
    datai_valid_d = 1'b0;
    read_outp_d   = 1'b0;
    bin_re_d      = bin_re_q;
    bin_im_d      = bin_im_q;
    bin_idx_d     = bin_idx_q;
    bin_valid_d   = 1'b0;
    frame_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A new run clears the host-visible status along with the counters.
        if (ENABLE) begin
          state_d      = S_LOAD;
          sample_cnt_d = '0;
          bin_cnt_d    = '0;
          idle_cnt_d   = '0;
          drop_cnt_d   = '0;
          err_d        = 1'b0;
        end
      end

      S_LOAD: begin
        if (ADC_VALID) begin
          if (FFT_BUF_READY) begin
            datai_valid_d = 1'b1;
            datai_re_d    = WIDTH'(adc_signed);
            sample_cnt_d  = sample_cnt_q + 1'b1;
            if (sample_cnt_q == LAST_IDX) begin
              state_d    = S_WAIT_OUT;
              idle_cnt_d = '0;
            end
          end else if (drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
          end
        end
      end

      S_WAIT_OUT: begin
        if (FFT_OUTP_READY) begin
          state_d     = S_READ;
          idle_cnt_d  = '0;
          read_outp_d = 1'b1;
        end else if (idle_inc == IDLE_LIMIT) begin
          state_d    = S_IDLE;
          idle_cnt_d = '0;
          err_d      = 1'b1;
        end else begin
          idle_cnt_d = idle_inc;
        end
      end

      S_READ: begin
        // The read-start pulse is already on the output during this state.
        state_d    = S_UNLOAD;
        idle_cnt_d = '0;
      end

      S_UNLOAD: begin
        if (FFT_DATAO_VALID) begin
          bin_valid_d = 1'b1;
          bin_re_d    = FFT_DATAO_RE;
          bin_im_d    = FFT_DATAO_IM;
          bin_idx_d   = bin_cnt_q;
          bin_cnt_d   = bin_cnt_q + 1'b1;
          idle_cnt_d  = '0;
          if (bin_cnt_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            if (ENABLE) begin
              // Back-to-back frame: status is kept, only frame counters restart.
              state_d      = S_LOAD;
              sample_cnt_d = '0;
              bin_cnt_d    = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else if (idle_inc == IDLE_LIMIT) begin
          state_d    = S_IDLE;
          idle_cnt_d = '0;
          err_d      = 1'b1;
        end else begin
          idle_cnt_d = idle_inc;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; async reset returns to IDLE.
  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      state_q       <= S_IDLE;
      sample_cnt_q  <= '0;
      bin_cnt_q     <= '0;
      idle_cnt_q    <= '0;
      drop_cnt_q    <= '0;
      err_q         <= 1'b0;
      datai_re_q    <= '0;
      datai_valid_q <= 1'b0;
      read_outp_q   <= 1'b0;
      bin_re_q      <= '0;
      bin_im_q      <= '0;
      bin_idx_q     <= '0;
      bin_valid_q   <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      sample_cnt_q  <= sample_cnt_d;
      bin_cnt_q     <= bin_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      err_q         <= err_d;
      datai_re_q    <= datai_re_d;
      datai_valid_q <= datai_valid_d;
      read_outp_q   <= read_outp_d;
      bin_re_q      <= bin_re_d;
      bin_im_q      <= bin_im_d;
      bin_idx_q     <= bin_idx_d;
      bin_valid_q   <= bin_valid_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign FFT_DATAI_RE    = datai_re_q;
  assign FFT_DATAI_IM    = '0;
  assign FFT_DATAI_VALID = datai_valid_q;
  assign FFT_READ_OUTP   = read_outp_q;
  assign BIN_RE          = bin_re_q;
  assign BIN_IM          = bin_im_q;
  assign BIN_IDX         = bin_idx_q;
  assign BIN_VALID       = bin_valid_q;
  assign FRAME_DONE      = frame_done_q;
  assign BUSY            = (state_q != S_IDLE);
  assign DROP_CNT        = drop_cnt_q;
  assign ERR_TIMEOUT     = err_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer: random ADC/core stimulus
// against expectations computed from the frame rules in plain arithmetic.
module tb_fft_frame_sequencer;

  localparam int POINTS   = 256;
  localparam int WIDTH    = 18;
  localparam int ADC_BITS = 12;
  localparam int TIMEOUT  = 15;
  localparam int IDX_W    = 8;

  logic                CLK = 1'b0;
  logic                NGRST;
  logic                ENABLE;
  logic [ADC_BITS-1:0] ADC_DATA;
  logic                ADC_VALID;
  logic                FFT_BUF_READY;
  logic [WIDTH-1:0]    FFT_DATAI_RE;
  logic [WIDTH-1:0]    FFT_DATAI_IM;
  logic                FFT_DATAI_VALID;
  logic                FFT_OUTP_READY;
  logic                FFT_READ_OUTP;
  logic [WIDTH-1:0]    FFT_DATAO_RE;
  logic [WIDTH-1:0]    FFT_DATAO_IM;
  logic                FFT_DATAO_VALID;
  logic [WIDTH-1:0]    BIN_RE;
  logic [WIDTH-1:0]    BIN_IM;
  logic [IDX_W-1:0]    BIN_IDX;
  logic                BIN_VALID;
  logic                FRAME_DONE;
  logic                BUSY;
  logic [7:0]          DROP_CNT;
  logic                ERR_TIMEOUT;

  logic [93:0] all_out;
  assign all_out = {FFT_DATAI_RE, FFT_DATAI_IM, FFT_DATAI_VALID, FFT_READ_OUTP,
                    BIN_RE, BIN_IM, BIN_IDX, BIN_VALID, FRAME_DONE, BUSY,
                    DROP_CNT, ERR_TIMEOUT};

  int n_checks  = 0;
  int n_fail    = 0;
  int exp_drops = 0;

  fft_frame_sequencer #(
    .POINTS  (POINTS),
    .WIDTH   (WIDTH),
    .ADC_BITS(ADC_BITS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK            (CLK),
    .NGRST          (NGRST),
    .ENABLE         (ENABLE),
    .ADC_DATA       (ADC_DATA),
    .ADC_VALID      (ADC_VALID),
    .FFT_BUF_READY  (FFT_BUF_READY),
    .FFT_DATAI_RE   (FFT_DATAI_RE),
    .FFT_DATAI_IM   (FFT_DATAI_IM),
    .FFT_DATAI_VALID(FFT_DATAI_VALID),
    .FFT_OUTP_READY (FFT_OUTP_READY),
    .FFT_READ_OUTP  (FFT_READ_OUTP),
    .FFT_DATAO_RE   (FFT_DATAO_RE),
    .FFT_DATAO_IM   (FFT_DATAO_IM),
    .FFT_DATAO_VALID(FFT_DATAO_VALID),
    .BIN_RE         (BIN_RE),
    .BIN_IM         (BIN_IM),
    .BIN_IDX        (BIN_IDX),
    .BIN_VALID      (BIN_VALID),
    .FRAME_DONE     (FRAME_DONE),
    .BUSY           (BUSY),
    .DROP_CNT       (DROP_CNT),
    .ERR_TIMEOUT    (ERR_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reset: every output low, FSM idle with ENABLE low.
  task automatic test_reset();
    NGRST = 1'b0; ENABLE = 1'b0; ADC_DATA = '0; ADC_VALID = 1'b0;
    FFT_BUF_READY = 1'b0; FFT_OUTP_READY = 1'b0; FFT_DATAO_RE = '0;
    FFT_DATAO_IM = '0; FFT_DATAO_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    NGRST = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (BUSY !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", BUSY);
    end
  endtask

  // From IDLE: raise ENABLE, expect LOAD with cleared status next cycle.
  task automatic start_run();
    ENABLE = 1'b1;
    @(negedge CLK);
    exp_drops = 0;
    n_checks++;
    if (BUSY !== 1'b1) begin
      n_fail++; $display("FAIL start_busy: got %b expected 1", BUSY);
    end
    n_checks++;
    if (DROP_CNT !== 8'd0 || ERR_TIMEOUT !== 1'b0) begin
      n_fail++; $display("FAIL start_status_clear: drop %0d err %b expected 0/0", DROP_CNT, ERR_TIMEOUT);
    end
  endtask

  // Load one frame starting at the current negedge (DUT in LOAD).
  // mode 0 random, 1 constant 0x800, 2 cycle {0x000,0xFFF,0x800,random}.
  task automatic do_load(input int mode, input int n_drops, input int drop_at, input int en_low_at);
    int accepted = 0;
    int drops_left = n_drops;
    int pulses = 0;
    int guard = 0;
    int cyc = 0;
    bit exp_v;
    int exp_re = 0;
    logic [ADC_BITS-1:0] d;
    bit v, r;
    forever begin
      if (en_low_at >= 0 && accepted >= en_low_at) ENABLE = 1'b0;
      v = ($urandom_range(0, 3) != 0);
      r = !(drops_left > 0 && accepted >= drop_at);
      case (mode)
        1: d = 12'h800;
        2: case (cyc % 4)
             0: d = 12'h000;
             1: d = 12'hFFF;
             2: d = 12'h800;
             default: d = ADC_BITS'($urandom_range(0, 4095));
           endcase
        default: d = ADC_BITS'($urandom_range(0, 4095));
      endcase
      cyc++;
      ADC_VALID = v; FFT_BUF_READY = r; ADC_DATA = d;
      exp_v = 1'b0;
      if (v && r) begin
        exp_v = 1'b1;
        exp_re = int'(d) - (1 << (ADC_BITS - 1));
        accepted++;
      end else if (v && !r) begin
        drops_left--;
        if (exp_drops < 255) exp_drops++;
      end
      @(negedge CLK);
      if (FFT_DATAI_VALID === 1'b1) pulses++;
      n_checks++;
      if (FFT_DATAI_VALID !== exp_v) begin
        n_fail++; $display("FAIL load_valid: got %b expected %b (accepted %0d)", FFT_DATAI_VALID, exp_v, accepted);
      end
      if (exp_v) begin
        n_checks++;
        if (int'($signed(FFT_DATAI_RE)) !== exp_re || FFT_DATAI_IM !== '0) begin
          n_fail++; $display("FAIL load_data: got re %0d im %h expected re %0d im 0 (adc %h)",
                             $signed(FFT_DATAI_RE), FFT_DATAI_IM, exp_re, d);
        end
      end
      if (accepted == POINTS) break;
      guard++;
      if (guard > 4000) begin
        n_checks++; n_fail++;
        $display("FAIL load_budget: only %0d samples accepted expected %0d", accepted, POINTS);
        break;
      end
    end
    ADC_VALID = 1'b0;
    n_checks++;
    if (pulses !== POINTS) begin
      n_fail++; $display("FAIL load_pulse_count: got %0d expected %0d", pulses, POINTS);
    end
    n_checks++;
    if (DROP_CNT !== 8'(exp_drops)) begin
      n_fail++; $display("FAIL load_drop_cnt: got %0d expected %0d", DROP_CNT, exp_drops);
    end
  endtask

  // WAIT_OUT for w cycles with ADC noise (ignored), then one read pulse.
  task automatic do_wait(input int w);
    for (int k = 0; k < w; k++) begin
      ADC_VALID = $urandom_range(0, 1) != 0;
      FFT_BUF_READY = $urandom_range(0, 1) != 0;
      ADC_DATA = ADC_BITS'($urandom);
      FFT_OUTP_READY = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (FFT_READ_OUTP !== 1'b0 || FFT_DATAI_VALID !== 1'b0 || DROP_CNT !== 8'(exp_drops)) begin
        n_fail++; $display("FAIL wait_quiet: read %b datai %b drop %0d expected 0/0/%0d",
                           FFT_READ_OUTP, FFT_DATAI_VALID, DROP_CNT, exp_drops);
      end
    end
    ADC_VALID = 1'b0;
    FFT_OUTP_READY = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (FFT_READ_OUTP !== 1'b1) begin
      n_fail++; $display("FAIL read_pulse: got %b expected 1", FFT_READ_OUTP);
    end
    FFT_OUTP_READY = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (FFT_READ_OUTP !== 1'b0 || BUSY !== 1'b1) begin
      n_fail++; $display("FAIL read_single: read %b busy %b expected 0/1", FFT_READ_OUTP, BUSY);
    end
  endtask

  // Core model streams n_bins results (RE = index) with short gaps.
  task automatic do_unload(input int n_bins, input bit en_at_end);
    int idx = 0;
    int gap = 0;
    int guard = 0;
    bit v, exp_v, exp_done;
    int exp_idx = 0;
    logic [WIDTH-1:0] exp_re, exp_im;
    exp_re = '0; exp_im = '0;
    ENABLE = en_at_end;
    forever begin
      v = ($urandom_range(0, 2) != 0) || (gap >= 3);
      FFT_DATAO_VALID = v;
      FFT_DATAO_IM = WIDTH'($urandom);
      exp_v = 1'b0; exp_done = 1'b0;
      if (v) begin
        FFT_DATAO_RE = WIDTH'(idx);
        exp_v = 1'b1; exp_idx = idx; exp_re = WIDTH'(idx); exp_im = FFT_DATAO_IM;
        exp_done = (idx == POINTS - 1);
        idx++; gap = 0;
      end else begin
        FFT_DATAO_RE = WIDTH'($urandom);
        gap++;
      end
      @(negedge CLK);
      n_checks++;
      if (BIN_VALID !== exp_v || FRAME_DONE !== exp_done) begin
        n_fail++; $display("FAIL bin_strobe: valid %b done %b expected %b/%b (bin %0d)",
                           BIN_VALID, FRAME_DONE, exp_v, exp_done, exp_idx);
      end
      if (exp_v) begin
        n_checks++;
        if (BIN_IDX !== IDX_W'(exp_idx) || BIN_RE !== exp_re || BIN_IM !== exp_im) begin
          n_fail++; $display("FAIL bin_data: idx %0d re %h im %h expected %0d %h %h",
                             BIN_IDX, BIN_RE, BIN_IM, exp_idx, exp_re, exp_im);
        end
      end
      if (idx == n_bins) break;
      guard++;
      if (guard > 2000) begin
        n_checks++; n_fail++;
        $display("FAIL unload_budget: %0d bins driven expected %0d", idx, n_bins);
        break;
      end
    end
    FFT_DATAO_VALID = 1'b0;
    if (n_bins == POINTS) begin
      n_checks++;
      if (BUSY !== en_at_end || ERR_TIMEOUT !== 1'b0) begin
        n_fail++; $display("FAIL frame_end_state: busy %b err %b expected %b/0", BUSY, ERR_TIMEOUT, en_at_end);
      end
    end
  endtask

  // Constant mid-scale frame, then a back-to-back frame with edge codes and drops.
  task automatic test_back_to_back();
    start_run();
    do_load(1, 0, 0, -1);
    do_wait($urandom_range(0, 12));
    do_unload(POINTS, 1'b1);
    do_load(2, 5, 40, -1);
    do_wait($urandom_range(0, 12));
    do_unload(POINTS, 1'b1);
  endtask

  // 300 drops within a frame saturate the counter at 255.
  task automatic test_drop_saturation();
    do_load(0, 300, 10, -1);
    do_wait($urandom_range(0, 12));
    do_unload(POINTS, 1'b1);
  endtask

  // ENABLE falls mid-frame: frame still completes, then IDLE ignores samples.
  task automatic test_enable_drop();
    do_load(0, 0, 0, 100);
    do_wait($urandom_range(0, 12));
    do_unload(POINTS, 1'b0);
    for (int k = 0; k < 4; k++) begin
      ADC_VALID = 1'b1; FFT_BUF_READY = (k % 2) == 0; ADC_DATA = ADC_BITS'($urandom);
      @(negedge CLK);
      n_checks++;
      if (FFT_DATAI_VALID !== 1'b0 || BUSY !== 1'b0 || DROP_CNT !== 8'(exp_drops)) begin
        n_fail++; $display("FAIL idle_ignore: datai %b busy %b drop %0d expected 0/0/%0d",
                           FFT_DATAI_VALID, BUSY, DROP_CNT, exp_drops);
      end
    end
    ADC_VALID = 1'b0;
  endtask

  // Core never signals ready: error exactly TIMEOUT cycles after WAIT_OUT entry.
  task automatic test_timeout();
    start_run();
    do_load(0, 0, 0, -1);
    FFT_OUTP_READY = 1'b0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge CLK);
      n_checks++;
      if (ERR_TIMEOUT !== (k == TIMEOUT) || BUSY !== (k != TIMEOUT) || FFT_READ_OUTP !== 1'b0) begin
        n_fail++; $display("FAIL timeout_cycle: k %0d err %b busy %b read %b expected %b/%b/0",
                           k, ERR_TIMEOUT, BUSY, FFT_READ_OUTP, (k == TIMEOUT), (k != TIMEOUT));
      end
    end
    @(negedge CLK);
    exp_drops = 0;
    n_checks++;
    if (ERR_TIMEOUT !== 1'b0 || BUSY !== 1'b1) begin
      n_fail++; $display("FAIL timeout_rearm: err %b busy %b expected 0/1", ERR_TIMEOUT, BUSY);
    end
  endtask

  // Asynchronous reset during UNLOAD clears everything; no bins until a new run.
  task automatic test_reset_unload();
    do_load(0, 0, 0, -1);
    do_wait($urandom_range(0, 12));
    do_unload(50, 1'b1);
    FFT_DATAO_VALID = 1'b1;
    FFT_DATAO_RE = WIDTH'($urandom);
    #2 NGRST = 1'b0;
    #1;
    n_checks++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL async_reset: got %h expected 0", all_out);
    end
    ENABLE = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) NGRST = 1'b1;
      FFT_DATAO_VALID = 1'b1;
      @(negedge CLK);
      n_checks++;
      if (BIN_VALID !== 1'b0 || BUSY !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_quiet: bin_valid %b busy %b expected 0/0", BIN_VALID, BUSY);
      end
    end
    FFT_DATAO_VALID = 1'b0;
    start_run();
    do_load(0, 0, 0, -1);
    do_wait($urandom_range(0, 12));
    do_unload(POINTS, 1'b0);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_drop_saturation();
    test_enable_drop();
    test_timeout();
    test_reset_unload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
